// File: rtl/mc_pkg.sv
// Shared types and encodings for the LEGv8 multicycle control unit.
// The alusrcb/aluop encodings are also used by aludec.
package mc_pkg;

    localparam int unsigned OP_W = 11;

    localparam logic [OP_W-1:0] OP_LDUR     = 11'b11111000010;
    localparam logic [OP_W-1:0] OP_STUR     = 11'b11111000000;
    localparam logic [OP_W-1:0] OP_CBZ      = 11'b10110100000;
    localparam logic [OP_W-1:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [OP_W-1:0] OP_B        = 11'b00010100000;
    localparam logic [OP_W-1:0] OP_B_MASK   = 11'b11111100000;
    localparam logic [OP_W-1:0] OP_ADD      = 11'b10001011000;
    localparam logic [OP_W-1:0] OP_SUB      = 11'b11001011000;
    localparam logic [OP_W-1:0] OP_AND      = 11'b10001010000;
    localparam logic [OP_W-1:0] OP_ORR      = 11'b10101010000;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_DOFS = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        CL_LDUR,
        CL_STUR,
        CL_CBZ,
        CL_B,
        CL_RTYPE,
        CL_ILLEGAL
    } opclass_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADDR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_JUMP
    } state_t;

    // Datapath control word driven out of the FSM each cycle.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pc_en;
        logic       pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       reg2loc;
        logic       regwrite;
        logic       memtoreg;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_if.sv
// Control/status bundle between mc_control and the multicycle datapath + memory.
interface mc_if;

    logic [mc_pkg::OP_W-1:0] opcode;
    logic                    zero;
    logic                    mem_ready;
    logic                    memread;
    logic                    memwrite;
    logic                    iord;
    logic                    irwrite;
    logic                    pc_en;
    logic                    pcsrc;
    logic                    alusrca;
    logic [1:0]              alusrcb;
    logic [1:0]              aluop;
    logic                    reg2loc;
    logic                    regwrite;
    logic                    memtoreg;
    logic                    illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output memread, memwrite, iord, irwrite, pc_en, pcsrc, alusrca,
               alusrcb, aluop, reg2loc, regwrite, memtoreg, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  memread, memwrite, iord, irwrite, pc_en, pcsrc, alusrca,
               alusrcb, aluop, reg2loc, regwrite, memtoreg, illegal
    );

endinterface

// File: rtl/mc_opclass.sv
// Combinational opcode classifier; only exact R-type encodings are accepted.
module mc_opclass
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output opclass_t        opclass_c
);

    always_comb begin
        opclass_c = CL_ILLEGAL;
        if (opcode == OP_LDUR) begin
            opclass_c = CL_LDUR;
        end else if (opcode == OP_STUR) begin
            opclass_c = CL_STUR;
        end else if ((opcode & OP_CBZ_MASK) == OP_CBZ) begin
            opclass_c = CL_CBZ;
        end else if ((opcode & OP_B_MASK) == OP_B) begin
            opclass_c = CL_B;
        end else if (opcode == OP_ADD || opcode == OP_SUB ||
                     opcode == OP_AND || opcode == OP_ORR) begin
            opclass_c = CL_RTYPE;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and counts retired instructions.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_if.master             bus,
    output logic [CNT_W-1:0] instret
);

    state_t   state_q;
    state_t   state_d;
    ctrl_t    ctrl;
    opclass_t opclass_c;
    logic     retire_c;

    mc_opclass u_opclass (
        .opcode    (bus.opcode),
        .opclass_c (opclass_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control word; outputs depend on state plus same-cycle handshakes.
    always_comb begin
        state_d  = state_q;
        ctrl     = '0;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = bus.mem_ready;
                ctrl.pc_en   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_BOFS;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.reg2loc = (opclass_c == CL_STUR) || (opclass_c == CL_CBZ);
                case (opclass_c)
                    CL_LDUR, CL_STUR: state_d = S_MEMADDR;
                    CL_RTYPE:         state_d = S_EXEC;
                    CL_CBZ:           state_d = S_BRANCH;
                    CL_B:             state_d = S_JUMP;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADDR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_DOFS;
                ctrl.aluop   = ALUOP_ADD;
                if (opclass_c == CL_LDUR)      state_d = S_MEMREAD;
                else if (opclass_c == CL_STUR) state_d = S_MEMWRITE;
                else                           state_d = S_FETCH;
            end
            S_MEMREAD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                retire_c      = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.reg2loc  = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_RTYPE;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                retire_c      = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_PASSB;
                ctrl.reg2loc = 1'b1;
                ctrl.pcsrc   = 1'b1;
                ctrl.pc_en   = bus.zero;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pcsrc = 1'b1;
                ctrl.pc_en = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Memory strobes and enables must drop the moment reset asserts.
        if (!reset) ctrl = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (retire_c) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign bus.memread  = ctrl.memread;
    assign bus.memwrite = ctrl.memwrite;
    assign bus.iord     = ctrl.iord;
    assign bus.irwrite  = ctrl.irwrite;
    assign bus.pc_en    = ctrl.pc_en;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.aluop    = ctrl.aluop;
    assign bus.reg2loc  = ctrl.reg2loc;
    assign bus.regwrite = ctrl.regwrite;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle vector table plus reset and counter-wrap sequences.
module tb_mc_control;
    import mc_pkg::*;

    // Control word order: memread memwrite iord irwrite pc_en pcsrc alusrca alusrcb aluop reg2loc regwrite memtoreg illegal
    localparam logic [14:0] C_ZERO    = 15'b0_0_0_0_0_0_0_00_00_0_0_0_0;
    localparam logic [14:0] C_FETCH_R = 15'b1_0_0_1_1_0_0_01_00_0_0_0_0;
    localparam logic [14:0] C_FETCH_W = 15'b1_0_0_0_0_0_0_01_00_0_0_0_0;
    localparam logic [14:0] C_DEC_N   = 15'b0_0_0_0_0_0_0_11_00_0_0_0_0;
    localparam logic [14:0] C_DEC_R2  = 15'b0_0_0_0_0_0_0_11_00_1_0_0_0;
    localparam logic [14:0] C_DEC_IL  = 15'b0_0_0_0_0_0_0_11_00_0_0_0_1;
    localparam logic [14:0] C_EXEC    = 15'b0_0_0_0_0_0_1_00_10_0_0_0_0;
    localparam logic [14:0] C_ALUWB   = 15'b0_0_0_0_0_0_0_00_00_0_1_0_0;
    localparam logic [14:0] C_MEMADDR = 15'b0_0_0_0_0_0_1_10_00_0_0_0_0;
    localparam logic [14:0] C_MEMRD   = 15'b1_0_1_0_0_0_0_00_00_0_0_0_0;
    localparam logic [14:0] C_MEMWB   = 15'b0_0_0_0_0_0_0_00_00_0_1_1_0;
    localparam logic [14:0] C_MEMWR   = 15'b0_1_1_0_0_0_0_00_00_1_0_0_0;
    localparam logic [14:0] C_BR_T    = 15'b0_0_0_0_1_1_1_00_01_1_0_0_0;
    localparam logic [14:0] C_BR_N    = 15'b0_0_0_0_0_1_1_00_01_1_0_0_0;
    localparam logic [14:0] C_JUMP    = 15'b0_0_0_0_1_1_0_00_00_0_0_0_0;

    localparam logic [10:0] I_ADD  = 11'b10001011000;
    localparam logic [10:0] I_SUB  = 11'b11001011000;
    localparam logic [10:0] I_ORR  = 11'b10101010000;
    localparam logic [10:0] I_LDUR = 11'b11111000010;
    localparam logic [10:0] I_STUR = 11'b11111000000;
    localparam logic [10:0] I_CBZ  = 11'b10110100101;
    localparam logic [10:0] I_B    = 11'b00010110011;
    localparam logic [10:0] I_ILL  = 11'b00000000000;
    localparam logic [10:0] I_NEAR = 11'b10001011001;

    typedef struct {
        logic [10:0] opcode;
        logic        zero;
        logic        mem_ready;
        logic [14:0] ctrl;
        int unsigned instret;
    } vec_t;

    typedef struct {
        logic [10:0] opcode;
        opclass_t    cls;
    } cls_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instret;
    logic [3:0]  instret4;
    logic [10:0] cls_op;
    opclass_t    cls_out;
    int          checks = 0;
    int          errors = 0;
    vec_t        vq[$];
    cls_vec_t    cq[$];

    mc_if bus ();
    mc_if bus4 ();

    mc_control dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .instret (instret)
    );

    mc_control #(.CNT_W(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus4),
        .instret (instret4)
    );

    mc_opclass u_cls (
        .opcode    (cls_op),
        .opclass_c (cls_out)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ctrl_word();
        return {bus.memread, bus.memwrite, bus.iord, bus.irwrite, bus.pc_en,
                bus.pcsrc, bus.alusrca, bus.alusrcb, bus.aluop, bus.reg2loc,
                bus.regwrite, bus.memtoreg, bus.illegal};
    endfunction

    function automatic vec_t mk(logic [10:0] op, logic z, logic mr, logic [14:0] c, int unsigned n);
        vec_t v;
        v.opcode = op; v.zero = z; v.mem_ready = mr; v.ctrl = c; v.instret = n;
        return v;
    endfunction

    function automatic cls_vec_t mkc(logic [10:0] op, opclass_t c);
        cls_vec_t v;
        v.opcode = op; v.cls = c;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Per-cycle sequence starting in the first cycle after reset release.
        vq.push_back(mk(I_ADD,  0, 1, C_FETCH_R, 0));
        vq.push_back(mk(I_ADD,  0, 1, C_DEC_N,   0));
        vq.push_back(mk(I_ADD,  0, 1, C_EXEC,    0));
        vq.push_back(mk(I_ADD,  0, 1, C_ALUWB,   0));
        vq.push_back(mk(I_LDUR, 0, 1, C_FETCH_R, 1));
        vq.push_back(mk(I_LDUR, 0, 1, C_DEC_N,   1));
        vq.push_back(mk(I_LDUR, 0, 1, C_MEMADDR, 1));
        vq.push_back(mk(I_LDUR, 0, 0, C_MEMRD,   1));
        vq.push_back(mk(I_LDUR, 0, 0, C_MEMRD,   1));
        vq.push_back(mk(I_LDUR, 0, 0, C_MEMRD,   1));
        vq.push_back(mk(I_LDUR, 0, 1, C_MEMRD,   1));
        vq.push_back(mk(I_LDUR, 0, 1, C_MEMWB,   1));
        vq.push_back(mk(I_STUR, 0, 0, C_FETCH_W, 2));
        vq.push_back(mk(I_STUR, 0, 1, C_FETCH_R, 2));
        vq.push_back(mk(I_STUR, 0, 1, C_DEC_R2,  2));
        vq.push_back(mk(I_STUR, 0, 0, C_MEMADDR, 2));
        vq.push_back(mk(I_STUR, 0, 0, C_MEMWR,   2));
        vq.push_back(mk(I_STUR, 0, 1, C_MEMWR,   2));
        vq.push_back(mk(I_CBZ,  1, 1, C_FETCH_R, 3));
        vq.push_back(mk(I_CBZ,  1, 1, C_DEC_R2,  3));
        vq.push_back(mk(I_CBZ,  1, 1, C_BR_T,    3));
        vq.push_back(mk(I_CBZ,  0, 1, C_FETCH_R, 4));
        vq.push_back(mk(I_CBZ,  0, 1, C_DEC_R2,  4));
        vq.push_back(mk(I_CBZ,  0, 1, C_BR_N,    4));
        vq.push_back(mk(I_ILL,  0, 1, C_FETCH_R, 5));
        vq.push_back(mk(I_ILL,  0, 1, C_DEC_IL,  5));
        vq.push_back(mk(I_B,    0, 1, C_FETCH_R, 5));
        vq.push_back(mk(I_B,    0, 1, C_DEC_N,   5));
        vq.push_back(mk(I_B,    1, 0, C_JUMP,    5));
        vq.push_back(mk(I_SUB,  0, 1, C_FETCH_R, 6));
        vq.push_back(mk(I_SUB,  0, 1, C_DEC_N,   6));
        vq.push_back(mk(I_SUB,  0, 0, C_EXEC,    6));
        vq.push_back(mk(I_SUB,  0, 0, C_ALUWB,   6));
        vq.push_back(mk(I_ORR,  0, 1, C_FETCH_R, 7));
        vq.push_back(mk(I_ORR,  0, 1, C_DEC_N,   7));
        vq.push_back(mk(I_ORR,  0, 1, C_EXEC,    7));
        vq.push_back(mk(I_ORR,  0, 1, C_ALUWB,   7));
        vq.push_back(mk(I_NEAR, 0, 1, C_FETCH_R, 8));
        vq.push_back(mk(I_NEAR, 0, 1, C_DEC_IL,  8));
        vq.push_back(mk(I_STUR, 0, 1, C_FETCH_R, 8));
        vq.push_back(mk(I_STUR, 0, 1, C_DEC_R2,  8));
        vq.push_back(mk(I_STUR, 0, 1, C_MEMADDR, 8));
        vq.push_back(mk(I_STUR, 0, 0, C_MEMWR,   8));
        vq.push_back(mk(I_STUR, 0, 0, C_MEMWR,   8));

        cq.push_back(mkc(11'b11111000010, CL_LDUR));
        cq.push_back(mkc(11'b11111000000, CL_STUR));
        cq.push_back(mkc(11'b10110100000, CL_CBZ));
        cq.push_back(mkc(11'b10110100111, CL_CBZ));
        cq.push_back(mkc(11'b00010111111, CL_B));
        cq.push_back(mkc(11'b10001010000, CL_RTYPE));
        cq.push_back(mkc(11'b10110101000, CL_ILLEGAL));
        cq.push_back(mkc(11'b11111000001, CL_ILLEGAL));
        cq.push_back(mkc(11'b10001011100, CL_ILLEGAL));

        reset          = 1'b0;
        bus.opcode     = I_ADD;
        bus.zero       = 1'b0;
        bus.mem_ready  = 1'b1;
        bus4.opcode    = I_B;
        bus4.zero      = 1'b0;
        bus4.mem_ready = 1'b1;

        foreach (cq[i]) begin
            cls_op = cq[i].opcode;
            #1;
            check("opclass", i, 32'(cls_out), 32'(cq[i].cls));
        end

        // Reset held with a fetch-ready memory: every output must stay low.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl", 0, 32'(ctrl_word()), 32'(C_ZERO));
        check("rst_instret", 0, instret, 32'd0);

        foreach (vq[i]) begin
            @(negedge clk);
            if (i == 0) reset = 1'b1;
            bus.opcode    = vq[i].opcode;
            bus.zero      = vq[i].zero;
            bus.mem_ready = vq[i].mem_ready;
            #1;
            check("ctrl", i, 32'(ctrl_word()), 32'(C_ZERO) | 32'(vq[i].ctrl));
            check("instret", i, instret, vq[i].instret);
        end

        // Reset in the middle of a stalled store drops memwrite at once.
        #2 reset = 1'b0;
        #1;
        check("midrst_memwrite", 0, 32'(bus.memwrite), 32'd0);
        check("midrst_ctrl", 0, 32'(ctrl_word()), 32'(C_ZERO));
        check("midrst_instret", 0, instret, 32'd0);
        @(negedge clk);
        #1;
        check("midrst_hold", 0, 32'(ctrl_word()), 32'(C_ZERO));
        @(negedge clk);
        reset         = 1'b1;
        bus.opcode    = I_ADD;
        bus.mem_ready = 1'b1;
        #1;
        check("postrst_fetch", 0, 32'(ctrl_word()), 32'(C_FETCH_R));
        check("postrst_instret", 0, instret, 32'd0);
        check("wrap_start", 0, 32'(instret4), 32'd0);

        // Narrow counter: a B retires every 3 cycles, so 16 of them wrap to 0.
        for (int n = 1; n <= 48; n++) begin
            @(negedge clk);
            #1;
            if (n == 3)  check("wrap", n, 32'(instret4), 32'd1);
            if (n == 45) check("wrap", n, 32'(instret4), 32'd15);
            if (n == 47) check("wrap", n, 32'(instret4), 32'd15);
            if (n == 48) check("wrap", n, 32'(instret4), 32'd0);
        end
        check("main_after_adds", 0, instret, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
